// File: rtl/rv_instr_encoder_pkg.sv
// ============================================================================
// Module      : rv_instr_encoder_pkg
// Description : RV32I integer-ALU op codes, opcodes and funct fields, shared
//               by the encoder and the decode stage so both use one table.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_instr_encoder_pkg;

  // ALU op selector as presented on the request interface
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;

  // Major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  // funct3 values
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // funct7 values: ALT selects SUB / SRA(I)
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  function automatic logic [2:0] funct3_of(input logic [3:0] op);
    logic [2:0] f3;
    case (op)
      OP_SLL:          f3 = F3_SLL;
      OP_SLT:          f3 = F3_SLT;
      OP_SLTU:         f3 = F3_SLTU;
      OP_XOR:          f3 = F3_XOR;
      OP_SRL, OP_SRA:  f3 = F3_SRL_SRA;
      OP_OR:           f3 = F3_OR;
      OP_AND:          f3 = F3_AND;
      default:         f3 = F3_ADD_SUB;
    endcase
    return f3;
  endfunction

  function automatic logic [6:0] funct7_of(input logic [3:0] op);
    return ((op == OP_SUB) || (op == OP_SRA)) ? F7_ALT : F7_BASE;
  endfunction

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

  // There is no SUBI: subtraction with an immediate is an ADDI of the negation
  function automatic logic is_legal(input logic is_imm, input logic [3:0] op);
    return (op <= OP_AND) && !(is_imm && (op == OP_SUB));
  endfunction

  // Packs a request into an R-type or I-type word. Shift immediates carry
  // funct7 in imm[11:5], so only the 5-bit shamt of the input is used.
  function automatic logic [31:0] encode_instr(
    input logic        is_imm,
    input logic [3:0]  op,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [11:0] imm
  );
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] imm_f;
    f3 = funct3_of(op);
    f7 = funct7_of(op);
    if (!is_imm) begin
      return {f7, rs2, rs1, f3, rd, OPC_OP};
    end
    imm_f = is_shift(op) ? {f7, imm[4:0]} : imm;
    return {imm_f, rs1, f3, rd, OPC_OP_IMM};
  endfunction

endpackage

`default_nettype wire

// File: rtl/rv_instr_encoder_sync_fifo.sv
// ============================================================================
// Module      : rv_instr_encoder_sync_fifo
// Description : Synchronous FIFO holding encoded words. DEPTH must be a power
//               of two so the pointers wrap naturally modulo DEPTH.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_instr_encoder_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  // Guard here as well so count can never overflow or underflow
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage, pointers and occupancy; reset clears everything so no stale word survives
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/rv_instr_encoder.sv
// ============================================================================
// Module      : rv_instr_encoder
// Description : Packs field-level ALU requests into RV32I R/I-type words,
//               drops illegal requests with a one-cycle err pulse, and buffers
//               legal words in a FIFO toward the decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_instr_encoder
  import rv_instr_encoder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic                       in_is_imm_i,
  input  logic [3:0]                 in_op_i,
  input  logic [4:0]                 in_rd_i,
  input  logic [4:0]                 in_rs1_i,
  input  logic [4:0]                 in_rs2_i,
  input  logic [11:0]                in_imm_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [31:0]                out_instr_o,
  output logic                       err_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  logic        accept;
  logic        legal;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic [31:0] word;
  logic [31:0] head;
  logic        err_d;
  logic        err_q;

  assign legal  = is_legal(in_is_imm_i, in_op_i);
  assign word   = encode_instr(in_is_imm_i, in_op_i, in_rd_i, in_rs1_i, in_rs2_i, in_imm_i);

  // in_ready comes only from occupancy, never from out_ready
  assign in_ready_o  = ~full;
  assign accept      = in_valid_i & in_ready_o;
  // Illegal requests complete the handshake but are not stored
  assign push        = accept & legal;
  assign out_valid_o = ~empty;
  assign pop         = out_valid_o & out_ready_i;
  // Present zero rather than a stale slot whenever nothing is buffered
  assign out_instr_o = empty ? 32'h0 : head;
  assign err_d       = accept & ~legal;
  assign err_o       = err_q;

  rv_instr_encoder_sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (word),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count_o)
  );

  // err pulses for the single cycle following an illegal accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rv_instr_encoder.sv
// ============================================================================
// Module      : tb_rv_instr_encoder
// Description : Directed self-checking bench for rv_instr_encoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv_instr_encoder;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_is_imm;
  logic [3:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [11:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        err;
  logic [2:0]  count;

  int n_pass;
  int n_total;

  rv_instr_encoder #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_is_imm_i (in_is_imm),
    .in_op_i     (in_op),
    .in_rd_i     (in_rd),
    .in_rs1_i    (in_rs1),
    .in_rs2_i    (in_rs2),
    .in_imm_i    (in_imm),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_instr_o (out_instr),
    .err_o       (err),
    .count_o     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic imm_sel, input logic [3:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
    in_is_imm = imm_sel;
    in_op     = op;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_imm    = imm;
  endtask

  // Present one request and hold it until accepted (bounded wait)
  task automatic send(input logic imm_sel, input logic [3:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
    int n;
    set_req(imm_sel, op, rd, rs1, rs2, imm);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'd0, 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 12'd0);

    // Reset state
    step();
    step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // ADD x1,x1,x2 with consumer ready: visible one cycle, then gone
    out_ready = 1'b1;
    send(1'b0, 4'd0, 5'd1, 5'd1, 5'd2, 12'd0);
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_instr", out_instr, 32'h002080B3);
    chk("add_count", {29'd0, count}, 32'd1);
    step();
    chk("add_valid_drop", {31'd0, out_valid}, 32'd0);
    chk("add_count_zero", {29'd0, count}, 32'd0);

    // SUB then ADDI back to back, popped in order
    send(1'b0, 4'd1, 5'd3, 5'd4, 5'd5, 12'd0);
    chk("sub_instr", out_instr, 32'h405201B3);
    send(1'b1, 4'd0, 5'd1, 5'd0, 5'd0, 12'hFFF);
    chk("addi_instr", out_instr, 32'hFFF00093);
    chk("addi_count", {29'd0, count}, 32'd1);
    step();
    chk("addi_drained", {29'd0, count}, 32'd0);

    // SRAI ignores imm[11:5]; head stable while not consumed
    out_ready = 1'b0;
    send(1'b1, 4'd7, 5'd2, 5'd2, 5'd0, 12'hFE3);
    chk("srai_instr", out_instr, 32'h40315113);
    step();
    chk("srai_stable", out_instr, 32'h40315113);
    out_ready = 1'b1;
    step();
    chk("srai_drained", {31'd0, out_valid}, 32'd0);

    // Fill to DEPTH with consumer stalled
    out_ready = 1'b0;
    send(1'b0, 4'd5, 5'd5, 5'd6, 5'd7, 12'd0);    // XOR
    send(1'b0, 4'd8, 5'd8, 5'd9, 5'd10, 12'd0);   // OR
    send(1'b0, 4'd9, 5'd11, 5'd12, 5'd13, 12'd0); // AND
    send(1'b1, 4'd2, 5'd14, 5'd15, 5'd0, 12'h01F); // SLLI shamt 31
    chk("full_count", {29'd0, count}, 32'd4);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("full_head", out_instr, 32'h007342B3);
    // Fifth request held while full
    set_req(1'b0, 4'd4, 5'd31, 5'd30, 5'd29, 12'd0); // SLTU
    in_valid = 1'b1;
    step();
    step();
    chk("full_held_count", {29'd0, count}, 32'd4);
    // Drain; the held request enters once a slot frees
    out_ready = 1'b1;
    step();
    chk("drain1_head", out_instr, 32'h00A4E433);
    chk("drain1_count", {29'd0, count}, 32'd3);
    chk("drain1_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("drain2_head", out_instr, 32'h00D675B3);
    chk("drain2_count", {29'd0, count}, 32'd3);
    step();
    chk("drain3_head", out_instr, 32'h01F79713);
    step();
    chk("drain4_head", out_instr, 32'h01DF3FB3);
    chk("drain4_count", {29'd0, count}, 32'd1);
    step();
    chk("drain_empty", {31'd0, out_valid}, 32'd0);
    step();
    chk("empty_pop_count", {29'd0, count}, 32'd0);

    // Illegal requests: accepted, err pulses, nothing stored
    send(1'b0, 4'd12, 5'd1, 5'd2, 5'd3, 12'd0);
    chk("ill_op_err", {31'd0, err}, 32'd1);
    chk("ill_op_count", {29'd0, count}, 32'd0);
    chk("ill_op_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk("ill_op_err_clear", {31'd0, err}, 32'd0);
    send(1'b1, 4'd1, 5'd1, 5'd2, 5'd0, 12'h005);
    chk("ill_subi_err", {31'd0, err}, 32'd1);
    chk("ill_subi_count", {29'd0, count}, 32'd0);
    chk("ill_subi_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk("ill_subi_err_clear", {31'd0, err}, 32'd0);

    // Asynchronous reset with three words buffered
    out_ready = 1'b0;
    send(1'b0, 4'd6, 5'd1, 5'd2, 5'd3, 12'd0);    // SRL
    send(1'b1, 4'd3, 5'd4, 5'd5, 5'd0, 12'h800);  // SLTI
    send(1'b0, 4'd0, 5'd1, 5'd1, 5'd2, 12'd0);    // ADD
    chk("pre_rst_count", {29'd0, count}, 32'd3);
    chk("pre_rst_head", out_instr, 32'h003150B3);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_count", {29'd0, count}, 32'd0);
    step();
    rst = 1'b0;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    send(1'b1, 4'd3, 5'd4, 5'd5, 5'd0, 12'h800);  // SLTI
    chk("post_rst_head", out_instr, 32'h8002A213);
    chk("post_rst_count", {29'd0, count}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rv_instr_encoder.md
Name: rv_instr_encoder

Overview:
- Produces RV32I integer-ALU instruction words from field-level requests, for the decode stage to consume.
- Accepts op, register and immediate fields over a valid/ready handshake.
- Packs each request into a 32-bit R-type or I-type word and buffers it in a small FIFO.
- Presents buffered words over a valid/ready output toward the decoder or a stimulus bench.

Parameters:
- DEPTH, 4: FIFO entries. Must be a power of two, at least 2.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  encoder can accept a request
- in_is_imm  in  1  0 = R-type (opcode 0110011), 1 = I-type (opcode 0010011)
- in_op  in  4  ALU op: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND; 10-15 illegal
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2 (ignored when in_is_imm=1)
- in_imm  in  12  immediate (only bits [4:0] used as shamt for shift ops)
- out_valid  out  1  out_instr holds a valid word
- out_ready  in  1  consumer takes the word
- out_instr  out  32  encoded instruction, FIFO head
- err  out  1  one-cycle pulse on an illegal request
- count  out  $clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (asynchronous): FIFO empty, read/write pointers 0, count=0, out_valid=0, out_instr=0, err=0. in_ready=1 in the first cycle after reset deasserts.
- Reset mid-operation discards all buffered words. No partial word is ever presented.
- Accept: in_valid & in_ready at a rising edge.
- Push: accept with a legal request writes the encoded word at the write pointer.
- Pop: out_valid & out_ready at a rising edge advances the read pointer.
- in_ready = (count != DEPTH). It does not depend on out_ready, so there is no combinational path from out_ready to in_ready.
- out_valid = (count != 0). out_instr is the registered head entry and is stable while out_valid=1 and out_ready=0.
- Latency: a word accepted at edge t is visible on out_instr/out_valid after edge t, provided the FIFO was empty. There is no same-cycle bypass.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Full: no accept. A pop on a full FIFO raises in_ready in the next cycle.
- Empty with out_ready=1: no pop, count stays 0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count must never exceed DEPTH or underflow.
- Encoding, computed combinationally from the inputs and registered into the FIFO:
  - funct3: ADD/SUB 000, SLL 001, SLT 010, SLTU 011, XOR 100, SRL/SRA 101, OR 110, AND 111.
  - R-type word: {funct7, rs2, rs1, funct3, rd, 7'b0110011}. funct7 = 0100000 for SUB and SRA, else 0000000.
  - I-type word, non-shift ops: {imm[11:0], rs1, funct3, rd, 7'b0010011}.
  - I-type word, shift ops: imm field = {funct7, imm[4:0]}. funct7 = 0100000 for SRAI, else 0000000. Input imm[11:5] is ignored.
- Illegal requests: in_op >= 10, or SUB with in_is_imm=1.
  - The request is still accepted (handshake completes) but nothing is pushed.
  - err=1 for exactly the cycle after the accept edge, then returns to 0.
  - An illegal request sent while the FIFO is full is not accepted, so err does not fire.

Decomposition:
- Shared package: op-code localparams (OP_ADD..OP_AND), opcode constants OPC_OP=0110011 and OPC_OP_IMM=0010011, funct3/funct7 constants.
- The same package is used by decode, so encode and decode share one table.
- One sub-module, sync_fifo (parameters WIDTH and DEPTH; push/pop/full/empty/count), holds the storage and pointers.
- The encoder proper is the packing logic plus the legality check.

Test Plan:
- Reset, then ADD rd=1 rs1=1 rs2=2 R-type with out_ready=1 -> out_instr=0x002080B3, out_valid high for exactly 1 cycle, count returns to 0.
- SUB rd=3 rs1=4 rs2=5 R-type, then ADDI rd=1 rs1=0 imm=0xFFF, out_ready=1 -> 0x405201B3 then 0xFFF00093, in order.
- SRAI rd=2 rs1=2 imm=0xFE3 -> 0x40315113, confirming imm[11:5] is ignored.
- Push 5 words with out_ready=0 and DEPTH=4 -> in_ready low after the 4th accept, count=4, 5th held. Then raise out_ready -> all 5 words drain in order and the pointers wrap.
- in_op=12, then SUB with in_is_imm=1 -> each accepted, err pulses 1 cycle each, count stays 0, out_valid stays 0.
- Assert rst for one cycle with count=3 -> out_valid=0, count=0 immediately (asynchronous). The next pushed word is output first, with no stale data.
